// File: rtl/occ_table_builder.sv
// Occ table writer for the FM-index accelerator: turns a BWT symbol stream into
// cumulative {t,g,c,a} count words, then publishes the C table and string length.
module occ_table_builder #(
  parameter int MAX_LEN = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sym_valid,
  input  logic [2:0]  sym,
  input  logic        sym_last,
  output logic        sym_ready,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        done,
  output logic        err,
  output logic [7:0]  len,
  output logic [31:0] c_tab
);

  typedef enum logic [1:0] {IDLE, BUILD, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);
  localparam logic [2:0] SYM_SENT = 3'd4;

  state_t           state_q, state_d;
  logic [3:0][7:0]  cnt_q, cnt_d, cnt_upd;
  logic [7:0]       index_q, index_d;
  logic             seen_q, seen_d;
  logic             err_q, err_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [7:0]       len_q, len_d;
  logic [31:0]      c_tab_q, c_tab_d;

  logic accept;
  logic is_sent, is_illegal, bad_sent, last_no_sent, overflow, abort;
  logic [7:0] c_c, c_g, c_t;

  // Sentinel and illegal codes match no lane, so their counts pass through unchanged.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign cnt_upd[gi] = cnt_q[gi] + {7'd0, (sym == 3'(gi))};
    end
  endgenerate

  assign accept       = (state_q == BUILD) && sym_valid;
  assign is_sent      = (sym == SYM_SENT);
  assign is_illegal   = (sym > SYM_SENT);
  assign bad_sent     = is_sent && seen_q;
  assign last_no_sent = sym_last && !seen_q && !is_sent;
  assign overflow     = (index_q == LAST_IDX) && !sym_last;
  assign abort        = is_illegal || bad_sent || last_no_sent || overflow;

  // C table from final counts; the sentinel occupies the single slot before 'a'.
  assign c_c = 8'd1 + cnt_upd[0];
  assign c_g = c_c + cnt_upd[1];
  assign c_t = c_g + cnt_upd[2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    index_d   = index_q;
    seen_d    = seen_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    len_d     = len_q;
    c_tab_d   = c_tab_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = BUILD;
          cnt_d   = '0;
          index_d = '0;
          seen_d  = 1'b0;
          err_d   = 1'b0;
          len_d   = '0;
          c_tab_d = '0;
        end
      end
      BUILD: begin
        if (accept) begin
          cnt_d     = cnt_upd;
          wr_en_d   = 1'b1;
          wr_addr_d = index_q;
          wr_data_d = cnt_upd;
          index_d   = index_q + 8'd1;
          seen_d    = seen_q || is_sent;
          if (abort) begin
            state_d = DONE;
            err_d   = 1'b1;
            len_d   = index_q + 8'd1;
            c_tab_d = '0;
          end else if (sym_last) begin
            state_d = DONE;
            len_d   = index_q + 8'd1;
            c_tab_d = {c_t, c_g, c_c, 8'd1};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      index_q   <= '0;
      seen_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      len_q     <= '0;
      c_tab_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      index_q   <= index_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      len_q     <= len_d;
      c_tab_q   <= c_tab_d;
    end
  end

  assign sym_ready = (state_q == BUILD);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign len       = len_q;
  assign c_tab     = c_tab_q;

endmodule

// File: tb/tb_occ_table_builder.sv
// Scoreboard bench for occ_table_builder: stimulus queues expected Occ writes,
// a negedge monitor pops and checks each wr_en pulse.
module tb_occ_table_builder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sym_valid;
  logic [2:0]  sym;
  logic        sym_last;
  logic        sym_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        done;
  logic        err;
  logic [7:0]  len;
  logic [31:0] c_tab;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        dn;
  } exp_t;
  exp_t sb[$];

  occ_table_builder #(.MAX_LEN(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sym_valid(sym_valid),
    .sym(sym), .sym_last(sym_last), .sym_ready(sym_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .err(err),
    .len(len), .c_tab(c_tab)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  // Monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write got addr=%h data=%h want no write", wr_addr, wr_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", wr_data, e.data);
        chk("done_at_write", 32'(done), 32'(e.dn));
        $display("write addr=%0d data=%h done=%0d", wr_addr, wr_data, done);
      end
    end
  end

  task automatic expect_wr(input logic [7:0] a, input logic [31:0] d, input logic dn);
    exp_t e;
    e.addr = a; e.data = d; e.dn = dn;
    sb.push_back(e);
  endtask

  task automatic send(input logic [2:0] s, input logic l, input int gap);
    int t;
    t = 0;
    sym_valid = 1'b1; sym = s; sym_last = l;
    while (sym_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (sym_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL ready_timeout got sym_ready=%b want 1", sym_ready);
    end
    @(posedge clk); #1;
    sym_valid = 1'b0; sym_last = 1'b0; sym = 3'd0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    @(negedge clk); @(negedge clk); #1;
    chk(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // a,c,$,g,a with last on the fifth symbol
  task automatic run_basic(input int gap);
    logic [2:0]  s[5];
    logic [31:0] d[5];
    s = '{3'd0, 3'd1, 3'd4, 3'd2, 3'd0};
    d = '{32'h00000001, 32'h00000101, 32'h00000101, 32'h00010101, 32'h00010102};
    for (int i = 0; i < 5; i++) begin
      expect_wr(8'(i), d[i], i == 4);
      send(s[i], i == 4, gap);
    end
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_err", 32'(err), 32'd0);
    chk("basic_len", 32'(len), 32'd5);
    chk("basic_ctab", c_tab, 32'h05040301);
    drain("basic_drain");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sym_valid = 1'b0; sym = 3'd0; sym_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(sym_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_len", 32'(len), 32'd0);
    chk("rst_ctab", c_tab, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(sym_ready), 32'd0);

    pulse_start();
    chk("build_ready", 32'(sym_ready), 32'd1);
    run_basic(0);

    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_ctab", c_tab, 32'd0);
    run_basic(3);

    // a,$,$ : second sentinel aborts
    pulse_start();
    expect_wr(8'd0, 32'h00000001, 1'b0); send(3'd0, 1'b0, 0);
    expect_wr(8'd1, 32'h00000001, 1'b0); send(3'd4, 1'b0, 0);
    expect_wr(8'd2, 32'h00000001, 1'b1); send(3'd4, 1'b1, 0);
    chk("dsent_err", 32'(err), 32'd1);
    chk("dsent_done", 32'(done), 32'd1);
    chk("dsent_len", 32'(len), 32'd3);
    chk("dsent_ctab", c_tab, 32'd0);
    drain("dsent_drain");

    // a,c with last and no sentinel
    pulse_start();
    chk("restart_err", 32'(err), 32'd0);
    expect_wr(8'd0, 32'h00000001, 1'b0); send(3'd0, 1'b0, 0);
    expect_wr(8'd1, 32'h00000101, 1'b1); send(3'd1, 1'b1, 0);
    chk("nosent_err", 32'(err), 32'd1);
    chk("nosent_len", 32'(len), 32'd2);
    chk("nosent_ctab", c_tab, 32'd0);
    drain("nosent_drain");

    // 255 symbols, all 't' except '$' at index 10, never last
    pulse_start();
    for (int i = 0; i < 255; i++) begin
      logic [7:0] tc;
      tc = (i < 10) ? 8'(i + 1) : 8'(i);
      expect_wr(8'(i), {tc, 24'h0}, i == 254);
      send((i == 10) ? 3'd4 : 3'd3, 1'b0, 0);
    end
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_done", 32'(done), 32'd1);
    chk("ovf_len", 32'(len), 32'd255);
    chk("ovf_ready", 32'(sym_ready), 32'd0);
    sym_valid = 1'b1; sym = 3'd3;
    repeat (4) @(posedge clk);
    #1; sym_valid = 1'b0;
    drain("ovf_drain");

    // start pulses mid-build must not restart the string
    pulse_start();
    expect_wr(8'd0, 32'h00000001, 1'b0); send(3'd0, 1'b0, 0);
    pulse_start();
    expect_wr(8'd1, 32'h00000101, 1'b0); send(3'd1, 1'b0, 1);
    pulse_start();
    expect_wr(8'd2, 32'h00000101, 1'b1); send(3'd4, 1'b1, 0);
    chk("filt_len", 32'(len), 32'd3);
    chk("filt_ctab", c_tab, 32'h03030201);
    chk("filt_err", 32'(err), 32'd0);
    drain("filt_drain");

    // reset while the third write is on the bus
    pulse_start();
    expect_wr(8'd0, 32'h00000001, 1'b0); send(3'd0, 1'b0, 0);
    expect_wr(8'd1, 32'h00000101, 1'b0); send(3'd1, 1'b0, 0);
    send(3'd2, 1'b0, 0);
    chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_data", wr_data, 32'd0);
    chk("mid_rst_ready", 32'(sym_ready), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    expect_wr(8'd0, 32'h00000000, 1'b0); send(3'd4, 1'b0, 0);
    expect_wr(8'd1, 32'h00000001, 1'b1); send(3'd0, 1'b1, 0);
    chk("post_rst_len", 32'(len), 32'd2);
    chk("post_rst_ctab", c_tab, 32'h02020201);
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
